// File: rtl/sprint2_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprint2_ctrl_pkg
// Brief    : Shared state/direction encodings and quadrature helpers for steering.
// Revision : 1.0
// ============================================================================
package sprint2_ctrl_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN_L = 2'd1;
    localparam logic [1:0] RUN_R = 2'd2;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b11;
    localparam logic [1:0] Q3 = 2'b10;

    // Right walks Q0->Q1->Q2->Q3->Q0; left walks the same ring backwards.
    function automatic logic [1:0] quad_next(input logic [1:0] phase, input logic go_right);
        logic [1:0] nxt;
        nxt = Q0;
        case (phase)
            Q0:      nxt = go_right ? Q1 : Q3;
            Q1:      nxt = go_right ? Q2 : Q0;
            Q2:      nxt = go_right ? Q3 : Q1;
            default: nxt = go_right ? Q0 : Q2;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_phase_gen
// Brief    : Gray-coded quadrature phase register and wrapping position counter.
// Revision : 1.0
// ============================================================================
module quad_phase_gen
    import sprint2_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       step,
    input  dir_t       dir,
    output logic [1:0] steer,
    output logic [7:0] position
);

    logic [1:0] r_phase;
    logic [7:0] r_pos;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_phase <= Q0;
            r_pos   <= 8'd0;
        end else if (step && (dir != DIR_NONE)) begin
            r_phase <= quad_next(r_phase, dir == DIR_R);
            r_pos   <= (dir == DIR_R) ? r_pos + 8'd1 : r_pos - 8'd1;
        end
    end

    assign steer    = r_phase;
    assign position = r_pos;

endmodule
`default_nettype wire

// File: rtl/steer_accel_quad.sv
`default_nettype none
// ============================================================================
// Module   : steer_accel_quad
// Brief    : Digital/analog steering request to accelerating quadrature stepper.
// Revision : 1.0
// ============================================================================
module steer_accel_quad
    import sprint2_ctrl_pkg::*;
#(
    parameter int BASE_DIV   = 22500,
    parameter int MIN_DIV    = 5625,
    parameter int ACCEL_STEP = 1125,
    parameter int ANALOG_DZ  = 8,
    parameter int ANALOG_K   = 160
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       ce,
    input  logic       left,
    input  logic       right,
    input  logic       analog_en,
    input  logic [7:0] analog_x,
    output logic [1:0] steer,
    output logic [7:0] position,
    output logic       active
);

    localparam logic [DIV_W-1:0] c_base  = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] c_min   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] c_accel = DIV_W'(ACCEL_STEP);
    localparam logic [7:0]       c_dz    = 8'(ANALOG_DZ);
    localparam logic [23:0]      c_k     = 24'(ANALOG_K);
    localparam logic [23:0]      c_span  = 24'(BASE_DIV - MIN_DIV);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cur_div;
    logic             r_active;
    logic             r_step;
    dir_t             r_step_dir;
    logic             r_analog_mode;

    logic [7:0]       w_mag;
    logic [7:0]       w_excess;
    logic [23:0]      w_prod;
    logic [DIV_W-1:0] w_target;
    dir_t             w_req;
    dir_t             w_run_dir;
    logic [DIV_W-1:0] w_reload;
    logic [DIV_W-1:0] w_eff_div;
    logic [DIV_W-1:0] w_accel_div;
    logic             w_fire;
    logic [1:0]       w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_step;
    dir_t             w_step_dir;

    // -128 has no positive twin in 8 bits, so it saturates to 127.
    always_comb begin
        w_mag = analog_x;
        if (analog_x == 8'h80) begin
            w_mag = 8'd127;
        end else if (analog_x[7]) begin
            w_mag = ~analog_x + 8'd1;
        end
        w_excess = (w_mag > c_dz) ? (w_mag - c_dz) : 8'd0;
        w_prod   = {16'd0, w_excess} * c_k;
        w_target = (w_prod >= c_span) ? c_min : (c_base - w_prod[DIV_W-1:0]);
    end

    always_comb begin
        w_req = DIR_NONE;
        if (analog_en) begin
            if (w_mag > c_dz) begin
                w_req = analog_x[7] ? DIR_L : DIR_R;
            end
        end else if (right && !left) begin
            w_req = DIR_R;
        end else if (left && !right) begin
            w_req = DIR_L;
        end
    end

    assign w_run_dir = (r_state == RUN_R) ? DIR_R : DIR_L;
    assign w_reload  = analog_en ? w_target : c_base;

    // Returning from analog to digital restarts the ramp from the slow rate.
    always_comb begin
        w_eff_div = r_cur_div;
        if (analog_en) begin
            w_eff_div = w_target;
        end else if (r_analog_mode) begin
            w_eff_div = c_base;
        end
        w_fire = (w_eff_div <= 16'd1) || (r_cnt >= (w_eff_div - 16'd1));
        w_accel_div = c_min;
        if ((w_eff_div > c_min) && ((w_eff_div - c_min) > c_accel)) begin
            w_accel_div = w_eff_div - c_accel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_cur_div;
        w_step      = 1'b0;
        w_step_dir  = DIR_NONE;
        case (r_state)
            IDLE: begin
                if (w_req != DIR_NONE) begin
                    w_state_nxt = (w_req == DIR_R) ? RUN_R : RUN_L;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = w_reload;
                end
            end
            RUN_L, RUN_R: begin
                if (w_req == DIR_NONE) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = c_base;
                end else if (w_req != w_run_dir) begin
                    w_state_nxt = (w_req == DIR_R) ? RUN_R : RUN_L;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = w_reload;
                end else if (w_fire) begin
                    w_step      = 1'b1;
                    w_step_dir  = w_run_dir;
                    w_cnt_nxt   = '0;
                    w_div_nxt   = analog_en ? w_target : w_accel_div;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
                    w_div_nxt   = w_eff_div;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_div_nxt   = c_base;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cur_div     <= c_base;
            r_active      <= 1'b0;
            r_step        <= 1'b0;
            r_step_dir    <= DIR_NONE;
            r_analog_mode <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (ce) begin
                r_state       <= w_state_nxt;
                r_cnt         <= w_cnt_nxt;
                r_cur_div     <= w_div_nxt;
                r_active      <= (w_state_nxt != IDLE);
                r_step        <= w_step;
                r_step_dir    <= w_step_dir;
                r_analog_mode <= analog_en;
            end
        end
    end

    quad_phase_gen u_phase (
        .CLK      (CLK),
        .reset    (reset),
        .step     (r_step),
        .dir      (r_step_dir),
        .steer    (steer),
        .position (position)
    );

    assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_steer_accel_quad.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_accel_quad
// Brief    : Directed self-checking bench for steer_accel_quad.
// Revision : 1.0
// ============================================================================
module tb_steer_accel_quad;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       analog_en = 1'b0;
    logic [7:0] analog_x = 8'd0;
    logic [1:0] steer;
    logic [7:0] position;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;

    steer_accel_quad #(
        .BASE_DIV   (8),
        .MIN_DIV    (2),
        .ACCEL_STEP (2),
        .ANALOG_DZ  (8),
        .ANALOG_K   (1)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .ce        (ce),
        .left      (left),
        .right     (right),
        .analog_en (analog_en),
        .analog_x  (analog_x),
        .steer     (steer),
        .position  (position),
        .active    (active)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Next posedge after this returns is the first ce with reset low.
    task automatic do_reset();
        reset = 1'b1;
        clocks(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        clocks(2);
        check("rst_steer", steer, 0);
        check("rst_pos", position, 0);
        check("rst_active", active, 0);

        // Digital right ramp: steps decided at ce 8,14,18,20,22
        right = 1'b1;
        do_reset();
        clocks(9);
        check("r_latency_steer", steer, 0);
        check("r_active", active, 1);
        clocks(1);
        check("r_s1_steer", steer, 1);
        check("r_s1_pos", position, 1);
        clocks(6);
        check("r_s2_steer", steer, 3);
        check("r_s2_pos", position, 2);
        clocks(4);
        check("r_s3_steer", steer, 2);
        check("r_s3_pos", position, 3);
        clocks(2);
        check("r_s4_steer", steer, 0);
        check("r_s4_pos", position, 4);
        clocks(2);
        check("r_s5_steer", steer, 1);
        check("r_s5_pos", position, 5);

        // Reversal after 10 ce of right
        right = 1'b1;
        left  = 1'b0;
        do_reset();
        clocks(10);
        right = 1'b0;
        left  = 1'b1;
        clocks(9);
        check("rev_before_steer", steer, 1);
        check("rev_before_pos", position, 1);
        clocks(1);
        check("rev_steer", steer, 0);
        check("rev_pos", position, 0);
        check("rev_active", active, 1);

        // Left from zero wraps position down to 255
        left  = 1'b1;
        right = 1'b0;
        do_reset();
        clocks(10);
        check("lwrap_steer", steer, 2);
        check("lwrap_pos", position, 255);

        // Both buttons pressed while running right drops to IDLE
        left  = 1'b0;
        right = 1'b1;
        do_reset();
        clocks(10);
        left = 1'b1;
        clocks(1);
        check("both_active", active, 0);
        clocks(20);
        check("both_steer_hold", steer, 1);
        check("both_pos_hold", position, 1);
        left  = 1'b0;
        right = 1'b0;

        // Analog full left: period floors at 2
        analog_en = 1'b1;
        analog_x  = 8'h80;
        do_reset();
        clocks(1);
        check("an_active", active, 1);
        clocks(2);
        check("an_latency_steer", steer, 0);
        clocks(1);
        check("an_s1_steer", steer, 2);
        check("an_s1_pos", position, 255);
        clocks(2);
        check("an_s2_steer", steer, 3);
        check("an_s2_pos", position, 254);
        analog_x = 8'd5;
        clocks(1);
        check("an_dz_active", active, 0);
        clocks(10);
        check("an_dz_pos", position, 254);

        // Upward wrap 255 -> 0 at full right deflection
        analog_x = 8'd127;
        do_reset();
        for (int i = 0; i < 1000 && position != 8'd255; i++) clocks(1);
        check("uwrap_reach", position, 255);
        for (int i = 0; i < 10 && position == 8'd255; i++) clocks(1);
        check("uwrap_pos", position, 0);
        clocks(5);
        reset = 1'b1;
        clocks(1);
        check("midrst_steer", steer, 0);
        check("midrst_pos", position, 0);
        check("midrst_active", active, 0);
        analog_en = 1'b0;
        analog_x  = 8'd0;

        // ce held low freezes the divider count
        right = 1'b1;
        do_reset();
        clocks(5);
        ce = 1'b0;
        clocks(50);
        check("ce_steer", steer, 0);
        check("ce_pos", position, 0);
        check("ce_active", active, 1);
        ce = 1'b1;
        clocks(4);
        check("ce_resume_steer", steer, 0);
        clocks(1);
        check("ce_step_steer", steer, 1);
        check("ce_step_pos", position, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
